instr_field_splitter: RTL and testbench

Decode-side counterpart of the jump-address builder: accepts a fetched 32-bit instruction plus its PC+4 and splits it into the MIPS instruction fields and jump-address components. These are the upper 4 PC bits and the 28-bit shifted target that the fetch side later recombines into a 32-bit jump address. Sits between fetch and decode as a 2-entry skid buffer with valid/ready on both sides, so fetch stalls never drop or duplicate an instruction.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/instr_fields.sv | 47 ++++
 rtl/instr_field_splitter.sv | 94 +++++++++
 tb/tb_instr_field_splitter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, field bit positions
// and the buffered fetch entry {instr, pc4}.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // Least-significant bit of each instruction field
    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;

    // Most-significant bit of the immediate and jump-index fields
    localparam int IMM_MSB    = 15;
    localparam int JIDX_MSB   = 25;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational decode of one instruction word plus its PC+4 into MIPS fields.
// Ports: valid/instr/pc4 in; field, jump-component and class outputs (all 0 when !valid).
module instr_fields
    import mips_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [31:0] imm_sext,
    output logic [3:0]  pc_upper4,
    output logic [27:0] jtarget28,
    output logic [31:0] pc4_out,
    output logic        is_rtype,
    output logic        is_jump
);

    logic [31:0] w;
    logic [31:0] p;

    // Masking the inputs forces every field to 0 for an empty head
    assign w = valid ? instr : '0;
    assign p = valid ? pc4   : '0;

    assign opcode    = w[OPCODE_LSB +: 6];
    assign rs        = w[RS_LSB +: 5];
    assign rt        = w[RT_LSB +: 5];
    assign rd        = w[RD_LSB +: 5];
    assign shamt     = w[SHAMT_LSB +: 5];
    assign funct     = w[FUNCT_LSB +: 6];
    assign imm16     = w[IMM_MSB:0];
    assign imm_sext  = {{16{w[IMM_MSB]}}, w[IMM_MSB:0]};
    assign jtarget28 = {w[JIDX_MSB:0], 2'b00};
    assign pc_upper4 = p[31:28];
    assign pc4_out   = p;

    // Opcode 0 is also what an empty head decodes to, so qualify with valid
    assign is_rtype  = valid && (opcode == OP_RTYPE);
    assign is_jump   = valid && ((opcode == OP_J) || (opcode == OP_JAL));

endmodule

// File: rtl/instr_field_splitter.sv
// Two-entry skid buffer between fetch and decode that splits the head entry into MIPS fields.
// Ports: Clk/Reset, in_* (fetch side), flush, out_valid/out_ready, decoded head fields.
module instr_field_splitter
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc4,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [31:0] imm_sext,
    output logic [3:0]  pc_upper4,
    output logic [27:0] jtarget28,
    output logic [31:0] pc4_out,
    output logic        is_rtype,
    output logic        is_jump
);

    entry_t      mem [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    entry_t      head_entry;

    // Ready depends only on registered count, never on out_ready
    assign in_ready  = (count != 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count  <= 2'd0;
            head   <= 1'b0;
            tail   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= '{instr: in_instr, pc4: in_pc4};
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    assign head_entry = mem[head];

    instr_fields u_fields (
        .valid     (out_valid),
        .instr     (head_entry.instr),
        .pc4       (head_entry.pc4),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm16     (imm16),
        .imm_sext  (imm_sext),
        .pc_upper4 (pc_upper4),
        .jtarget28 (jtarget28),
        .pc4_out   (pc4_out),
        .is_rtype  (is_rtype),
        .is_jump   (is_jump)
    );

endmodule

// File: tb/tb_instr_field_splitter.sv
// Directed self-checking bench for instr_field_splitter.
// Drives #1 after each rising edge; samples just after the drive or mid-cycle.
module tb_instr_field_splitter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] imm_sext;
    logic [3:0]  pc_upper4;
    logic [27:0] jtarget28;
    logic [31:0] pc4_out;
    logic        is_rtype;
    logic        is_jump;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    instr_field_splitter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm16     (imm16),
        .imm_sext  (imm_sext),
        .pc_upper4 (pc_upper4),
        .jtarget28 (jtarget28),
        .pc4_out   (pc4_out),
        .is_rtype  (is_rtype),
        .is_jump   (is_jump)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] bp_instr [4];
    logic [31:0] bp_pc4   [4];
    int          idx;
    int          pop_idx;
    logic        acc;

    initial begin
        bp_instr[0] = 32'h2001_0011; bp_pc4[0] = 32'h0040_0004;
        bp_instr[1] = 32'h2002_0022; bp_pc4[1] = 32'h0040_0008;
        bp_instr[2] = 32'h2003_0033; bp_pc4[2] = 32'h0040_000C;
        bp_instr[3] = 32'h2004_0044; bp_pc4[3] = 32'h0040_0010;

        Reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc4 = '0;
        flush = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_is_rtype", 32'(is_rtype), 32'd0);
        check("rst_pc4_out", pc4_out, 32'd0);
        step();
        Reset = 1'b0;

        // Single accept of a j instruction
        in_valid = 1'b1; in_instr = 32'h0810_0004; in_pc4 = 32'hA000_0010;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("j_out_valid", 32'(out_valid), 32'd1);
        check("j_opcode", 32'(opcode), 32'h02);
        check("j_is_jump", 32'(is_jump), 32'd1);
        check("j_is_rtype", 32'(is_rtype), 32'd0);
        check("j_pc_upper4", 32'(pc_upper4), 32'hA);
        check("j_jtarget28", 32'(jtarget28), 32'h040_0010);
        check("j_target", {pc_upper4, jtarget28}, 32'hA040_0010);
        check("j_pc4_out", pc4_out, 32'hA000_0010);
        step();
        check("j_popped", 32'(out_valid), 32'd0);

        // R-type add $t1,$t2,$t3
        in_valid = 1'b1; in_instr = 32'h014B_4820; in_pc4 = 32'h0000_0104;
        step();
        check("r_rs", 32'(rs), 32'd10);
        check("r_rt", 32'(rt), 32'd11);
        check("r_rd", 32'(rd), 32'd9);
        check("r_shamt", 32'(shamt), 32'd0);
        check("r_funct", 32'(funct), 32'h20);
        check("r_is_rtype", 32'(is_rtype), 32'd1);
        check("r_is_jump", 32'(is_jump), 32'd0);

        // Sign extension, negative then positive immediate
        in_instr = 32'h2128_FFFC; in_pc4 = 32'h0000_0108;
        step();
        check("sx_opcode", 32'(opcode), 32'h08);
        check("sx_imm16", 32'(imm16), 32'h0000_FFFC);
        check("sx_neg", imm_sext, 32'hFFFF_FFFC);
        in_instr = 32'h2128_7FFF; in_pc4 = 32'h0000_010C;
        step();
        check("sx_pos", imm_sext, 32'h0000_7FFF);
        check("sx_pc4", pc4_out, 32'h0000_010C);
        in_valid = 1'b0;
        step();
        check("sx_drained", 32'(out_valid), 32'd0);

        // Backpressure: out_ready low for the first three cycles
        idx = 0;
        pop_idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid  = (idx < 4);
            in_instr  = (idx < 4) ? bp_instr[idx] : 32'd0;
            in_pc4    = (idx < 4) ? bp_pc4[idx]   : 32'd0;
            out_ready = (cyc >= 3);
            #3;
            if (cyc == 2) begin
                check("bp_full_in_ready", 32'(in_ready), 32'd0);
                check("bp_full_out_valid", 32'(out_valid), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (pop_idx < 4) begin
                    check("bp_order_imm", 32'(imm16),
                          32'(bp_instr[pop_idx][15:0]));
                    check("bp_order_pc4", pc4_out, bp_pc4[pop_idx]);
                end else begin
                    check("bp_duplicate", pc4_out, 32'd0);
                end
                pop_idx++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        check("bp_all_out", 32'(pop_idx), 32'd4);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush with a full buffer plus concurrent push and pop attempts
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0C00_0AAA; in_pc4 = 32'h1000_0004;
        step();
        in_instr = 32'h0C00_0BBB; in_pc4 = 32'h1000_0008;
        step();
        check("fl_full", 32'(in_ready), 32'd0);
        in_instr = 32'h0C00_0CCC; in_pc4 = 32'h1000_000C;
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_opcode", 32'(opcode), 32'd0);
        check("fl_jtarget", 32'(jtarget28), 32'd0);
        check("fl_pc4_out", pc4_out, 32'd0);
        check("fl_is_jump", 32'(is_jump), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("fl_stays_empty", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1; in_instr = 32'h0800_0DDD; in_pc4 = 32'h2000_0004;
        step();
        in_valid = 1'b0;
        check("fl_next_valid", 32'(out_valid), 32'd1);
        check("fl_next_pc4", pc4_out, 32'h2000_0004);
        step();

        // Asynchronous reset between edges with one entry held
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h2000_1234; in_pc4 = 32'h3000_0004;
        step();
        in_valid = 1'b0;
        check("ar_before", 32'(out_valid), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check("ar_imm16", 32'(imm16), 32'd0);
        #3;
        Reset = 1'b0;
        in_valid = 1'b1; in_instr = 32'h2000_5678; in_pc4 = 32'h4000_0004;
        step();
        in_valid = 1'b0;
        check("ar_new_valid", 32'(out_valid), 32'd1);
        check("ar_new_imm16", 32'(imm16), 32'h0000_5678);
        check("ar_new_pc4", pc4_out, 32'h4000_0004);
        out_ready = 1'b1;
        step();
        check("ar_drained", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
